// File: rtl/uart_text_pkg.sv
// Shared types and ASCII constants for the UART text receiver.
// Optional control-code handling is enabled with UART_TEXT_CTRL_EN.
package uart_text_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/uart_rx_core.sv
// UART 8N1 deserializer: 2-flop synchronizer, bit FSM, byte/strobe outputs.
// done/data expose the completed byte combinationally for same-edge consumers.
module uart_rx_core
    import uart_text_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       framing_err,
    output logic       done,
    output logic [7:0] data
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta;
    logic          rx_s;
    rx_state_e     state_q;
    rx_state_e     state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [2:0]    idx_q;
    logic [2:0]    idx_d;
    logic [7:0]    sh_q;
    logic [7:0]    sh_d;
    logic          ferr;

    // Bring the asynchronous line into the clock domain (idle high).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: next state, counters and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        done    = 1'b0;
        ferr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not turn into 0x00 bytes.
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered byte/strobe outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            rx_byte     <= '0;
            rx_valid    <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            rx_valid    <= done;
            framing_err <= ferr;
            if (done) rx_byte <= sh_q;
        end
    end

    assign data = sh_q;

endmodule

// File: rtl/uart_text_rx.sv
// UART receiver feeding a scrolling ASCII buffer for the 7-segment displays.
// Define UART_TEXT_CTRL_EN to interpret BS, CR and LF instead of shifting them.
module uart_text_rx
    import uart_text_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042,
    parameter int NUM_CHARS    = 5
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      rx,
    input  logic                      clear,
    output logic [NUM_CHARS-1:0][7:0] chars,
    output logic [7:0]                rx_byte,
    output logic                      rx_valid,
    output logic                      framing_err
);

    logic                      done;
    logic [7:0]                data;
    logic [NUM_CHARS-1:0][7:0] chars_q;
    logic [NUM_CHARS-1:0][7:0] chars_d;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_core (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .framing_err(framing_err),
        .done       (done),
        .data       (data)
    );

    // Next buffer contents; clear overrides an arriving byte.
    always_comb begin
        chars_d = chars_q;
        if (clear) begin
            chars_d = {NUM_CHARS{ASCII_SPACE}};
        end else if (done) begin
`ifdef UART_TEXT_CTRL_EN
            unique case (1'b1)
                (data == ASCII_BS):
                    chars_d = {ASCII_SPACE, chars_q[NUM_CHARS-1:1]};
                (data == ASCII_CR):
                    chars_d = {NUM_CHARS{ASCII_SPACE}};
                (data == ASCII_LF):
                    chars_d = chars_q;
                default:
                    chars_d = {chars_q[NUM_CHARS-2:0], data};
            endcase
`else
            chars_d = {chars_q[NUM_CHARS-2:0], data};
`endif
        end
    end

    // Character buffer register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) chars_q <= {NUM_CHARS{ASCII_SPACE}};
        else        chars_q <= chars_d;
    end

    assign chars = chars_q;

endmodule

// File: tb/tb_uart_text_rx.sv
// Directed self-checking bench for uart_text_rx (CLKS_PER_BIT=16, NUM_CHARS=5).
// Honors UART_TEXT_CTRL_EN for the control-code expectations.
module tb_uart_text_rx;

    localparam int CPB = 16;
    localparam int NC  = 5;

    logic              clk;
    logic              n_rst;
    logic              rx;
    logic              clear;
    logic [NC-1:0][7:0] chars;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              framing_err;

    int checks;
    int errors;
    int nvalid;
    int nwide;
    int nferr;
    logic prev_valid;

    uart_text_rx #(
        .CLKS_PER_BIT(CPB),
        .NUM_CHARS   (NC)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rx         (rx),
        .clear      (clear),
        .chars      (chars),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .framing_err(framing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes away from the active edge.
    initial begin
        nvalid     = 0;
        nwide      = 0;
        nferr      = 0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid) nvalid++;
            if (rx_valid && prev_valid) nwide++;
            if (framing_err) nferr++;
            prev_valid = rx_valid;
        end
    end

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_chars(input string name, input logic [NC*8-1:0] exp);
        checks++;
        if (chars !== exp) begin
            errors++;
            $display("FAIL %s chars got %h expected %h", name, chars, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        chk_chars("reset_chars", {NC{8'h20}});
        checks++;
        if (rx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_rx_byte got %h expected 00", rx_byte);
        end
        checks++;
        if (rx_valid !== 1'b0 || framing_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes got %b%b expected 00",
                     rx_valid, framing_err);
        end
    endtask

    task automatic test_hello();
        int v0, w0, f0;
        v0 = nvalid; w0 = nwide; f0 = nferr;
        send(8'h48, 1'b1); idle_bits(2);
        send(8'h45, 1'b1); idle_bits(2);
        send(8'h4C, 1'b1); idle_bits(2);
        send(8'h4C, 1'b1); idle_bits(2);
        send(8'h4F, 1'b1); idle_bits(2);
        chk_chars("hello", {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F});
        checks++;
        if (nvalid - v0 !== 5) begin
            errors++;
            $display("FAIL hello_valid_count got %0d expected 5", nvalid - v0);
        end
        checks++;
        if (nwide - w0 !== 0) begin
            errors++;
            $display("FAIL hello_valid_width got %0d wide expected 0",
                     nwide - w0);
        end
        checks++;
        if (nferr - f0 !== 0) begin
            errors++;
            $display("FAIL hello_ferr got %0d expected 0", nferr - f0);
        end
    endtask

    task automatic test_back_to_back();
        int v0;
        logic [7:0] msg [6];
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21};
        v0 = nvalid;
        for (int i = 0; i < 6; i++) begin
            send(msg[i], 1'b1);
            @(negedge clk);
        end
        idle_bits(2);
        chk_chars("b2b", {8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21});
        checks++;
        if (rx_byte !== 8'h21) begin
            errors++;
            $display("FAIL b2b_rx_byte got %h expected 21", rx_byte);
        end
        checks++;
        if (nvalid - v0 !== 6) begin
            errors++;
            $display("FAIL b2b_valid_count got %0d expected 6", nvalid - v0);
        end
    endtask

    task automatic test_framing();
        int v0, f0;
        v0 = nvalid; f0 = nferr;
        send(8'h41, 1'b0);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        idle_bits(3);
        checks++;
        if (nferr - f0 !== 1) begin
            errors++;
            $display("FAIL ferr_count got %0d expected 1", nferr - f0);
        end
        checks++;
        if (nvalid - v0 !== 0) begin
            errors++;
            $display("FAIL ferr_valid got %0d expected 0", nvalid - v0);
        end
        chk_chars("ferr_chars", {8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21});
        checks++;
        if (rx_byte !== 8'h21) begin
            errors++;
            $display("FAIL ferr_rx_byte got %h expected 21", rx_byte);
        end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = nvalid; f0 = nferr;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        checks++;
        if (nvalid - v0 !== 0 || nferr - f0 !== 0) begin
            errors++;
            $display("FAIL glitch_strobes got v%0d f%0d expected v0 f0",
                     nvalid - v0, nferr - f0);
        end
        send(8'h5A, 1'b1);
        idle_bits(2);
        checks++;
        if (rx_byte !== 8'h5A) begin
            errors++;
            $display("FAIL glitch_next_byte got %h expected 5A", rx_byte);
        end
        chk_chars("glitch_chars", {8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h5A});
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int v0;
        b = 8'h55;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = b[3];
        repeat (CPB / 2) @(negedge clk);
        n_rst = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        idle_bits(2);
        v0 = nvalid;
        send(8'h42, 1'b1);
        idle_bits(2);
        checks++;
        if (nvalid - v0 !== 1 || rx_byte !== 8'h42) begin
            errors++;
            $display("FAIL rst_mid got v%0d byte %h expected v1 byte 42",
                     nvalid - v0, rx_byte);
        end
        chk_chars("rst_mid_chars", {8'h20, 8'h20, 8'h20, 8'h20, 8'h42});
    endtask

    task automatic test_clear();
        int v0;
        send(8'h31, 1'b1);
        idle_bits(1);
        chk_chars("pre_clear", {8'h20, 8'h20, 8'h20, 8'h42, 8'h31});
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_chars("clear", {NC{8'h20}});
        v0 = nvalid;
        clear = 1'b1;
        send(8'h32, 1'b1);
        idle_bits(1);
        clear = 1'b0;
        idle_bits(1);
        chk_chars("clear_wins", {NC{8'h20}});
        checks++;
        if (rx_byte !== 8'h32 || nvalid - v0 !== 1) begin
            errors++;
            $display("FAIL clear_byte got %h v%0d expected 32 v1",
                     rx_byte, nvalid - v0);
        end
    endtask

    task automatic test_ctrl();
        do_reset();
        send(8'h41, 1'b1); idle_bits(1);
        send(8'h42, 1'b1); idle_bits(1);
        send(8'h08, 1'b1); idle_bits(1);
`ifdef UART_TEXT_CTRL_EN
        chk_chars("ctrl_bs", {8'h20, 8'h20, 8'h20, 8'h20, 8'h41});
`else
        chk_chars("ctrl_bs", {8'h20, 8'h20, 8'h41, 8'h42, 8'h08});
`endif
        send(8'h0D, 1'b1); idle_bits(1);
`ifdef UART_TEXT_CTRL_EN
        chk_chars("ctrl_cr", {NC{8'h20}});
`else
        chk_chars("ctrl_cr", {8'h20, 8'h41, 8'h42, 8'h08, 8'h0D});
`endif
        checks++;
        if (rx_byte !== 8'h0D) begin
            errors++;
            $display("FAIL ctrl_rx_byte got %h expected 0D", rx_byte);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n_rst  = 1'b1;
        rx     = 1'b1;
        clear  = 1'b0;
        test_reset();
        test_hello();
        test_back_to_back();
        test_framing();
        test_glitch();
        test_reset_midframe();
        test_clear();
        test_ctrl();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_text_rx.md
Name: uart_text_rx

Overview:
UART 8N1 receiver with a NUM_CHARS-deep ASCII character shift buffer, sitting directly upstream of the alpha_display 7-segment decoders in the lcd-uart-receiver design. Serial bytes from the board RX pin are deserialized and shifted into the buffer. Each buffer slot drives one alpha_display instance, so the displays scroll received text right-to-left. The block also exposes the raw byte and valid strobe for other consumers.

Parameters:
CLKS_PER_BIT, 1042, clock cycles per bit period (10 MHz / 9600 baud); must be >= 4
NUM_CHARS, 5, number of character slots in the display buffer

Ports:
clk  input  1  system clock
n_rst  input  1  reset; asynchronous assert, active-low
rx  input  1  asynchronous serial line, idle high
clear  input  1  synchronous clear; sets all buffer slots to 8'h20
chars  output  [NUM_CHARS-1:0][7:0]  character buffer; chars[NUM_CHARS-1] is the leftmost display (HEX4), chars[0] the rightmost (HEX0)
rx_byte  output  8  last good byte received
rx_valid  output  1  one-cycle pulse when rx_byte updates
framing_err  output  1  one-cycle pulse on a bad stop bit

Behaviour:
- Reset: all chars = 8'h20 (space); rx_byte = 0; rx_valid = 0; framing_err = 0; FSM = IDLE; synchronizer flops = 1.
- rx passes through a 2-flop synchronizer, rx_s. All decisions use rx_s.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits.
- FSM states:
  - IDLE: when rx_s == 0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2 - 1, sample rx_s. If 0, go to DATA and clear the counter. If 1, treat it as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - If 1: go to IDLE, load rx_byte, pulse rx_valid, and shift the byte into the buffer.
    - If 0: pulse framing_err, make no buffer or rx_byte change, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a break condition from producing 0x00 bytes.
- Shift on a good byte: chars[i] <= chars[i-1] for i >= 1, and chars[0] <= the new byte. The oldest character drops off chars[NUM_CHARS-1].
- Timing: rx_valid asserts on the clock edge after the stop-bit sample. chars updates on the same edge.
- Line-to-valid latency is 2 cycles (synchronizer) + 9.5 bit periods + 1 cycle.
- clear and shift in the same cycle: clear wins and the byte is discarded from the buffer. rx_byte and rx_valid still update.
- clear has no effect on the FSM.
- Reset mid-frame: the FSM returns to IDLE and the partial byte is lost.
- Back-to-back frames: a start edge in the cycle immediately after STOP exits must be detected.

Optional Feature:
- Macro: UART_TEXT_CTRL_EN
- Defined:
  - 8'h08 (backspace) shifts the buffer right: chars[i] <= chars[i+1], and chars[NUM_CHARS-1] <= 8'h20.
  - 8'h0D (CR) sets all slots to 8'h20.
  - 8'h0A (LF) leaves the buffer unchanged.
  - rx_byte and rx_valid still report these bytes.
- Undefined: every good byte, including control codes, shifts in literally.

Decomposition:
- Package uart_text_pkg:
  - state enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - ASCII_SPACE = 8'h20, ASCII_BS = 8'h08, ASCII_CR = 8'h0D, ASCII_LF = 8'h0A
- Sub-module uart_rx_core: synchronizer, FSM, counters, rx_byte / rx_valid / framing_err.
- The top level holds the character buffer and control-code handling.

Test Plan (CLKS_PER_BIT = 16, NUM_CHARS = 5):
- Reset, then send "HELLO" (48 45 4C 4C 4F) -> chars[4:0] = 48,45,4C,4C,4F; five rx_valid pulses, each 1 cycle wide; framing_err never set.
- Send "HELLO!" back-to-back with no idle gap -> chars[4:0] = 45,4C,4C,4F,21; rx_byte = 8'h21.
- Send 8'h41 with stop bit = 0, holding rx low for 3 more bit periods -> one framing_err pulse; chars and rx_byte unchanged; no rx_valid.
- Hold rx low for 4 cycles, then release -> no rx_valid and no framing_err; FSM back to IDLE.
- Assert n_rst during bit 3 of 8'h55, then send 8'h42 -> only 8'h42 is received; chars[0] = 42.
- With UART_TEXT_CTRL_EN: after reset send 41, 42, 08 -> chars[4:0] = 20,20,20,20,41. Then send 0D -> all slots = 20. Without the macro, the same stimulus gives chars[4:0] = 20,41,42,08,0D.
